// File: rtl/player_motion_ctrl.sv
// Frame-rate walk/jump/gravity sequencer for the player sprite; all state steps on frame_end.
// Optional build macro AUTO_PATROL_EN: auto-walk in the facing direction when no single horizontal button is held.
module player_motion_ctrl #(
    parameter int RANGE_X    = 624,
    parameter int RANGE_Y    = 368,
    parameter int WALK_SPEED = 1,
    parameter int JUMP_VEL   = 12,
    parameter int GRAVITY    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_end,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    output logic [9:0] px,
    output logic [9:0] py,
    output logic       airborne,
    output logic       facing,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_GROUND = 2'b00,
        ST_RISE   = 2'b01,
        ST_FALL   = 2'b10,
        ST_BAD    = 2'b11
    } state_e;

    logic [2:0] sync1_q, sync2_q;
    logic [9:0] px_q, px_d, py_q, py_d;
    logic [4:0] vy_q, vy_d;
    state_e     state_q, state_d;
    logic       facing_q, facing_d;
    logic       airborne_q, airborne_d;
    logic       jump_prev_q, jump_prev_d;

    logic       s_left, s_right, s_jump, jump_edge;
    logic [10:0] px_inc, py_sum;
    logic [9:0]  px_right, px_left;
    logic [5:0]  nv_full;
    logic [4:0]  nv;

    // Two-flop synchronizers for {jump, right, left}
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {btn_jump, btn_right, btn_left};
            sync2_q <= sync1_q;
        end
    end

    assign s_left    = sync2_q[0];
    assign s_right   = sync2_q[1];
    assign s_jump    = sync2_q[2];
    assign jump_edge = s_jump & ~jump_prev_q;

    // Saturating horizontal steps, computed one bit wider than px so nothing wraps
    assign px_inc   = {1'b0, px_q} + 11'(WALK_SPEED);
    assign px_right = (px_inc > 11'(RANGE_X)) ? 10'(RANGE_X) : px_inc[9:0];
    assign px_left  = ({1'b0, px_q} < 11'(WALK_SPEED)) ? '0 : px_q - 10'(WALK_SPEED);

    assign py_sum   = {1'b0, py_q} + {6'b0, vy_q};
    assign nv_full  = {1'b0, vy_q} + 6'(GRAVITY);
    assign nv       = (nv_full > 6'(JUMP_VEL)) ? 5'(JUMP_VEL) : nv_full[4:0];

    always_comb begin
        px_d        = px_q;
        py_d        = py_q;
        vy_d        = vy_q;
        state_d     = state_q;
        facing_d    = facing_q;
        jump_prev_d = jump_prev_q;

        if (frame_end) begin
            jump_prev_d = s_jump;

            if (s_right && !s_left) begin
                px_d     = px_right;
                facing_d = 1'b1;
            end else if (s_left && !s_right) begin
                px_d     = px_left;
                facing_d = 1'b0;
            end
`ifdef AUTO_PATROL_EN
            else if (facing_q) begin
                px_d = px_right;
                if (px_right == 10'(RANGE_X)) facing_d = 1'b0;
            end else begin
                px_d = px_left;
                if (px_left == '0) facing_d = 1'b1;
            end
`endif

            case (state_q)
                ST_GROUND: begin
                    if (jump_edge) begin
                        state_d = ST_RISE;
                        vy_d    = 5'(JUMP_VEL);
                    end else begin
                        py_d = '0;
                    end
                end
                ST_RISE: begin
                    if (py_sum >= 11'(RANGE_Y)) begin
                        py_d    = 10'(RANGE_Y);
                        state_d = ST_FALL;
                        vy_d    = '0;
                    end else begin
                        py_d = py_sum[9:0];
                        if (vy_q <= 5'(GRAVITY)) begin
                            state_d = ST_FALL;
                            vy_d    = '0;
                        end else begin
                            vy_d = vy_q - 5'(GRAVITY);
                        end
                    end
                end
                ST_FALL: begin
                    if (py_q <= {5'b0, nv}) begin
                        state_d = ST_GROUND;
                        py_d    = '0;
                        vy_d    = '0;
                    end else begin
                        py_d = py_q - {5'b0, nv};
                        vy_d = nv;
                    end
                end
                default: begin
                    // Illegal encoding: recover to ground
                    state_d = ST_GROUND;
                    py_d    = '0;
                    vy_d    = '0;
                end
            endcase
        end

        airborne_d = (state_d == ST_RISE) || (state_d == ST_FALL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            px_q        <= '0;
            py_q        <= '0;
            vy_q        <= '0;
            state_q     <= ST_GROUND;
            facing_q    <= 1'b1;
            airborne_q  <= 1'b0;
            jump_prev_q <= 1'b0;
        end else begin
            px_q        <= px_d;
            py_q        <= py_d;
            vy_q        <= vy_d;
            state_q     <= state_d;
            facing_q    <= facing_d;
            airborne_q  <= airborne_d;
            jump_prev_q <= jump_prev_d;
        end
    end

    assign px       = px_q;
    assign py       = py_q;
    assign airborne = airborne_q;
    assign facing   = facing_q;
    assign state    = state_q;

endmodule
